// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI write arbiter.
//   arb_state_t : arbiter FSM state encoding
//   BRESP_OKAY  : AXI OKAY write response
//   *_W_DEF     : default widths used by the arbiter parameters
package axi_arb_pkg;

  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req_i : request vector, bit 0 = m0, bit 1 = m1
//   ptr_i : priority pointer, 0 = m0 wins a tie, 1 = m1 wins a tie
//   gnt_o : one-hot grant, 0 when nothing is requested
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master write-channel arbiter in front of a single AXI write slave.
// One master is granted for one complete single-beat write (AW, W, B),
// then the arbiter re-arbitrates with round-robin priority.
//   clk, areset         : clock and asynchronous active-low reset
//   m0_* / m1_*         : master AW/W inputs, ready and B outputs
//   s_*                 : slave AW/W outputs, ready and B inputs
//   gnt_o               : one-hot current grant (0 when idle)
//   busy_o              : high whenever a write is in flight
//
// state | meaning
// IDLE  | no grant; sample AW valids and arbitrate
// XFER  | granted master's AW/W routed to the slave until both handshake
// RESP  | slave B routed to the granted master until B handshake
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [ID_W-1:0]     m0_awid_i,
  input  logic [ADDR_W-1:0]   m0_awaddr_i,
  input  logic                m0_awvalid_i,
  output logic                m0_awready_o,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  input  logic                m0_wlast_i,
  input  logic                m0_wvalid_i,
  output logic                m0_wready_o,
  output logic [ID_W-1:0]     m0_bid_o,
  output logic [1:0]          m0_bresp_o,
  output logic                m0_bvalid_o,
  input  logic                m0_bready_i,
  input  logic [ID_W-1:0]     m1_awid_i,
  input  logic [ADDR_W-1:0]   m1_awaddr_i,
  input  logic                m1_awvalid_i,
  output logic                m1_awready_o,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  input  logic                m1_wlast_i,
  input  logic                m1_wvalid_i,
  output logic                m1_wready_o,
  output logic [ID_W-1:0]     m1_bid_o,
  output logic [1:0]          m1_bresp_o,
  output logic                m1_bvalid_o,
  input  logic                m1_bready_i,
  output logic [ID_W-1:0]     s_awid_o,
  output logic [ADDR_W-1:0]   s_awaddr_o,
  output logic                s_awvalid_o,
  input  logic                s_awready_i,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  output logic                s_wlast_o,
  output logic                s_wvalid_o,
  input  logic                s_wready_i,
  input  logic [ID_W-1:0]     s_bid_i,
  input  logic [1:0]          s_bresp_i,
  input  logic                s_bvalid_i,
  output logic                s_bready_o,
  output logic [1:0]          gnt_o,
  output logic                busy_o
);

  arb_state_t state_q;
  logic [1:0] gnt_q;
  logic       ptr_q;
  logic       aw_done_q;
  logic       w_done_q;
  logic       busy_q;

  logic [1:0] arb_gnt;
  logic       in_xfer, in_resp;
  logic       aw_vld_sel, w_vld_sel, b_rdy_sel;
  logic       aw_hs, w_hs, b_hs;

  rr_arb2 u_rr_arb2 (
    .req_i ({m1_awvalid_i, m0_awvalid_i}),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  assign in_xfer = (state_q == XFER);
  assign in_resp = (state_q == RESP);

  // Forward mux; the grant register is zero in IDLE, so payload reads 0 there.
  always_comb begin
    s_awid_o   = '0;
    s_awaddr_o = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    s_wlast_o  = 1'b0;
    aw_vld_sel = 1'b0;
    w_vld_sel  = 1'b0;
    b_rdy_sel  = 1'b0;
    if (gnt_q[0]) begin
      s_awid_o   = m0_awid_i;
      s_awaddr_o = m0_awaddr_i;
      s_wdata_o  = m0_wdata_i;
      s_wstrb_o  = m0_wstrb_i;
      s_wlast_o  = m0_wlast_i;
      aw_vld_sel = m0_awvalid_i;
      w_vld_sel  = m0_wvalid_i;
      b_rdy_sel  = m0_bready_i;
    end else if (gnt_q[1]) begin
      s_awid_o   = m1_awid_i;
      s_awaddr_o = m1_awaddr_i;
      s_wdata_o  = m1_wdata_i;
      s_wstrb_o  = m1_wstrb_i;
      s_wlast_o  = m1_wlast_i;
      aw_vld_sel = m1_awvalid_i;
      w_vld_sel  = m1_wvalid_i;
      b_rdy_sel  = m1_bready_i;
    end
  end

  // A channel that already handshook is masked so the slave never sees it twice.
  assign s_awvalid_o = in_xfer & ~aw_done_q & aw_vld_sel;
  assign s_wvalid_o  = in_xfer & ~w_done_q  & w_vld_sel;
  assign s_bready_o  = in_resp & b_rdy_sel;

  assign aw_hs = s_awvalid_o & s_awready_i;
  assign w_hs  = s_wvalid_o  & s_wready_i;
  assign b_hs  = s_bvalid_i  & s_bready_o;

  assign m0_awready_o = in_xfer & gnt_q[0] & ~aw_done_q & s_awready_i;
  assign m1_awready_o = in_xfer & gnt_q[1] & ~aw_done_q & s_awready_i;
  assign m0_wready_o  = in_xfer & gnt_q[0] & ~w_done_q  & s_wready_i;
  assign m1_wready_o  = in_xfer & gnt_q[1] & ~w_done_q  & s_wready_i;

  assign m0_bvalid_o = in_resp & gnt_q[0] & s_bvalid_i;
  assign m1_bvalid_o = in_resp & gnt_q[1] & s_bvalid_i;
  assign m0_bid_o    = (in_resp & gnt_q[0]) ? s_bid_i   : '0;
  assign m1_bid_o    = (in_resp & gnt_q[1]) ? s_bid_i   : '0;
  assign m0_bresp_o  = (in_resp & gnt_q[0]) ? s_bresp_i : 2'b00;
  assign m1_bresp_o  = (in_resp & gnt_q[1]) ? s_bresp_i : 2'b00;

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      ptr_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_awvalid_i || m1_awvalid_i) begin
            state_q <= XFER;
            gnt_q   <= arb_gnt;
            busy_q  <= 1'b1;
          end
        end
        XFER: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
            // Priority goes to the master that was not just served.
            ptr_q     <= gnt_q[0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
